// File: rtl/drum_step_sequencer.sv
// Purpose: step sequencer turning the divided ~48 kHz sample clock into per-voice one-cycle drum triggers from a writable pattern.
// Latency: sample_clk rise -> sample_tick after 3 clkin cycles -> step_strobe/trig/step_idx registered one cycle later.
// Backpressure: none; triggers are fire-and-forget pulses and pattern writes are accepted every cycle. Optional macro: DRUM_SEQ_SWING_EN.
module drum_step_sequencer #(
    parameter int NUM_VOICES = 4,
    parameter int NUM_STEPS  = 16,
    parameter int STEP_W     = $clog2(NUM_STEPS)
) (
    input  logic                          clkin,
    input  logic                          reset,
    input  logic                          sample_clk,
    input  logic                          run,
    input  logic [15:0]                   samples_per_step,
    input  logic                          wr_en,
    input  logic [$clog2(NUM_VOICES)-1:0] wr_voice,
    input  logic [STEP_W-1:0]             wr_step,
    input  logic                          wr_data,
`ifdef DRUM_SEQ_SWING_EN
    input  logic [15:0]                   swing_samples,
`endif
    output logic [NUM_VOICES-1:0]         trig,
    output logic                          step_strobe,
    output logic [STEP_W-1:0]             step_idx,
    output logic                          busy
);

    localparam int VW = $clog2(NUM_VOICES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        RUN  = 2'd2
    } state_t;

    state_t                               state;
    logic [NUM_VOICES-1:0][NUM_STEPS-1:0] pattern;
    logic [16:0]                          counter;

    logic sync1;
    logic sync2;
    logic sync2_d;
    logic sample_tick;

    logic [16:0]           eff_len;
    logic [16:0]           step_len;
    logic [16:0]           last_cnt;
    logic [STEP_W-1:0]     next_step;
    logic [NUM_VOICES-1:0] col_next;
    logic [NUM_VOICES-1:0] col_zero;
`ifdef DRUM_SEQ_SWING_EN
    logic [16:0]           swing_amt;
`endif

    // Bring sample_clk into the clkin domain and turn each rise into a one-cycle registered tick.
    always_ff @(posedge clkin) begin
        if (reset) begin
            sync1       <= 1'b0;
            sync2       <= 1'b0;
            sync2_d     <= 1'b0;
            sample_tick <= 1'b0;
        end else begin
            sync1       <= sample_clk;
            sync2       <= sync1;
            sync2_d     <= sync2;
            sample_tick <= sync2 & ~sync2_d;
        end
    end

    // Length of the current step in ticks; 17 bits because swing can push an even step past 16 bits.
    always_comb begin
        eff_len = (samples_per_step == 16'd0) ? 17'd1 : {1'b0, samples_per_step};
`ifdef DRUM_SEQ_SWING_EN
        // Clamp so an odd step never drops below one tick; the pair total stays 2*eff_len.
        swing_amt = ({1'b0, swing_samples} >= (eff_len - 17'd1)) ? (eff_len - 17'd1)
                                                                  : {1'b0, swing_samples};
        step_len  = step_idx[0] ? (eff_len - swing_amt) : (eff_len + swing_amt);
`else
        step_len  = eff_len;
`endif
        last_cnt  = step_len - 17'd1;
    end

    // Pattern columns for the step about to be entered (read before any same-cycle write lands).
    always_comb begin
        next_step = step_idx + STEP_W'(1);
        col_next  = '0;
        col_zero  = '0;
        for (int v = 0; v < NUM_VOICES; v++) begin
            col_next[v] = pattern[v][next_step];
            col_zero[v] = pattern[v][0];
        end
    end

    // Pattern storage: writable in any state; voice indices with no matching voice are dropped.
    always_ff @(posedge clkin) begin
        if (reset) begin
            pattern <= '0;
        end else if (wr_en) begin
            for (int v = 0; v < NUM_VOICES; v++) begin
                if (wr_voice == VW'(v)) begin
                    pattern[v][wr_step] <= wr_data;
                end
            end
        end
    end

    // Sequencer FSM with registered step index, pulses and busy flag.
    always_ff @(posedge clkin) begin
        if (reset) begin
            state       <= IDLE;
            counter     <= '0;
            step_idx    <= '0;
            trig        <= '0;
            step_strobe <= 1'b0;
            busy        <= 1'b0;
        end else begin
            trig        <= '0;
            step_strobe <= 1'b0;
            case (state)
                IDLE: begin
                    busy     <= 1'b0;
                    step_idx <= '0;
                    counter  <= '0;
                    if (run) begin
                        state <= ARM;
                    end
                end
                ARM: begin
                    if (!run) begin
                        state <= IDLE;
                    end else if (sample_tick) begin
                        // This tick is the entry of step 0.
                        state       <= RUN;
                        busy        <= 1'b1;
                        step_idx    <= '0;
                        counter     <= '0;
                        step_strobe <= 1'b1;
                        trig        <= col_zero;
                    end
                end
                RUN: begin
                    if (!run) begin
                        // Stopping wins over a coincident step entry; restart always begins at step 0.
                        state    <= IDLE;
                        busy     <= 1'b0;
                        step_idx <= '0;
                        counter  <= '0;
                    end else if (sample_tick) begin
                        // >= lets a shrunk step length take effect on the very next tick.
                        if (counter >= last_cnt) begin
                            step_idx    <= next_step;
                            counter     <= '0;
                            step_strobe <= 1'b1;
                            trig        <= col_next;
                        end else begin
                            counter <= counter + 17'd1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_drum_step_sequencer.sv
// Bench for drum_step_sequencer: clkin period 10, sample_clk period 20 clkin.
// A tick-level reference model pushes expected step entries; the DUT's step_strobe pops and checks them.
// Hand-written sequences cover stop/restart, shrinking step length, same-cycle writes and reset.
module tb_drum_step_sequencer;

    localparam int NV = 4;
    localparam int NS = 16;

    logic          clkin = 1'b0;
    logic          reset;
    logic          sample_clk;
    logic          run;
    logic [15:0]   samples_per_step;
    logic          wr_en;
    logic [1:0]    wr_voice;
    logic [3:0]    wr_step;
    logic          wr_data;
    logic [NV-1:0] trig;
    logic          step_strobe;
    logic [3:0]    step_idx;
    logic          busy;
`ifdef DRUM_SEQ_SWING_EN
    logic [15:0]   swing_samples;
`endif

    drum_step_sequencer #(.NUM_VOICES(NV), .NUM_STEPS(NS)) dut (
        .clkin            (clkin),
        .reset            (reset),
        .sample_clk       (sample_clk),
        .run              (run),
        .samples_per_step (samples_per_step),
        .wr_en            (wr_en),
        .wr_voice         (wr_voice),
        .wr_step          (wr_step),
        .wr_data          (wr_data),
`ifdef DRUM_SEQ_SWING_EN
        .swing_samples    (swing_samples),
`endif
        .trig             (trig),
        .step_strobe      (step_strobe),
        .step_idx         (step_idx),
        .busy             (busy)
    );

    always #5 clkin = ~clkin;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- sample clock source ----------------
    logic sclk_en  = 1'b0;
    int   sph      = 10;
    int   tick_due = -100;   // posedge at which the DUT acts on the latest rise (rise + 3 sync/detect + 1)

    always @(negedge clkin) begin
        if (sclk_en) begin
            sph        = (sph + 1) % 20;
            sample_clk = (sph < 10);
            if (sph == 0) tick_due = cyc + 4;
        end
    end

    // ---------------- reference model + scoreboard ----------------
    typedef struct {
        int            step;
        logic [NV-1:0] trig;
        int            cyc;
    } exp_t;
    exp_t sb[$];

    int                   m_state = 0;  // 0 idle, 1 armed, 2 running
    int                   m_step  = 0;
    int                   m_cnt   = 0;
    logic [NV-1:0][NS-1:0] m_pat  = '0;

    function automatic int m_len();
        int e;
        e = (samples_per_step == 0) ? 1 : int'(samples_per_step);
`ifdef DRUM_SEQ_SWING_EN
        begin
            int s;
            s = (int'(swing_samples) > e - 1) ? e - 1 : int'(swing_samples);
            e = (m_step % 2 == 1) ? e - s : e + s;
        end
`endif
        return e;
    endfunction

    task automatic m_enter(input int step);
        exp_t e;
        m_step = step;
        m_cnt  = 0;
        e.step = step;
        e.cyc  = cyc;
        for (int v = 0; v < NV; v++) e.trig[v] = m_pat[v][step];
        sb.push_back(e);
    endtask

    always @(posedge clkin) begin
        cyc = cyc + 1;
        if (reset) begin
            m_state = 0; m_step = 0; m_cnt = 0; m_pat = '0;
            sb.delete();
        end else begin
            case (m_state)
                0: if (run) m_state = 1;
                1: begin
                    if (!run) m_state = 0;
                    else if (cyc == tick_due) begin m_enter(0); m_state = 2; end
                end
                default: begin
                    if (!run) begin
                        m_state = 0; m_step = 0; m_cnt = 0;
                    end else if (cyc == tick_due) begin
                        if (m_cnt >= m_len() - 1) m_enter((m_step + 1) % NS);
                        else m_cnt++;
                    end
                end
            endcase
            if (wr_en) m_pat[wr_voice][wr_step] = wr_data;
        end
    end

    // Continuous comparison of every DUT output against the model, away from the active edge.
    logic chk_en = 1'b0;
    always @(negedge clkin) begin
        if (chk_en) begin
            check("busy", busy, (m_state == 2));
            check("step_idx", step_idx, m_step);
            if (step_strobe) begin
                if (sb.size() == 0) begin
                    check("unexpected_strobe", 1, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("sb_step", step_idx, e.step);
                    check("sb_trig", trig, e.trig);
                    check("sb_time", cyc, e.cyc);
                end
            end else begin
                check("trig_without_strobe", trig, 0);
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic wait_strobe(output int t);
        int n = 0;
        do begin
            @(negedge clkin);
            n++;
        end while (!step_strobe && n < 3000);
        check("strobe_wait", step_strobe, 1);
        t = cyc;
    endtask

    task automatic write_bit(input int v, input int s, input logic d);
        @(negedge clkin);
        wr_en = 1'b1; wr_voice = 2'(v); wr_step = 4'(s); wr_data = d;
        @(negedge clkin);
        wr_en = 1'b0;
    endtask

    // Step-length table: samples_per_step -> expected strobe spacing in clkin cycles.
    typedef struct {
        logic [15:0] sps;
        int          period;
    } len_vec_t;

`ifdef DRUM_SEQ_SWING_EN
    typedef struct {
        logic [15:0] sps;
        logic [15:0] swing;
        int          even_p;
        int          odd_p;
    } swing_vec_t;
`endif

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        len_vec_t lv[5];
        int t0, t1, t2, tmp, n, cnt0;
        int s0, seen3;
        logic [NV-1:0] acc;
        logic [NV-1:0] trig3[2];
`ifdef DRUM_SEQ_SWING_EN
        swing_vec_t sv[2];
`endif
        lv[0] = '{16'd2, 40};
        lv[1] = '{16'd0, 20};
        lv[2] = '{16'd1, 20};
        lv[3] = '{16'd3, 60};
        lv[4] = '{16'd4, 80};
`ifdef DRUM_SEQ_SWING_EN
        sv[0] = '{16'd6, 16'd2,  160, 80};
        sv[1] = '{16'd6, 16'd10, 220, 20};
        swing_samples = '0;
`endif
        reset = 1'b1; run = 1'b0; samples_per_step = 16'd4;
        wr_en = 1'b0; wr_voice = '0; wr_step = '0; wr_data = 1'b0;
        sample_clk = 1'b0;
        chk_en = 1'b1; sclk_en = 1'b1;
        repeat (3) @(negedge clkin);
        check("rst_trig", trig, 0);
        check("rst_strobe", step_strobe, 0);
        check("rst_step", step_idx, 0);
        check("rst_busy", busy, 0);
        reset = 1'b0;
        repeat (10) @(negedge clkin);

        // Test 1: voice0 on 0,4,8,12; voice1 on 3; 4 ticks per step.
        write_bit(0, 0, 1'b1); write_bit(0, 4, 1'b1);
        write_bit(0, 8, 1'b1); write_bit(0, 12, 1'b1);
        write_bit(1, 3, 1'b1);
        samples_per_step = 16'd4; run = 1'b1;
        cnt0 = 0;
        for (int i = 0; i < 17; i++) begin
            wait_strobe(tmp);
            if (i == 0)  check("t1_first_step", step_idx, 0);
            if (i == 15) check("t1_last_step", step_idx, 15);
            if (i == 16) check("t1_wrap_step", step_idx, 0);
            if (i > 0 && i < 16) check("t1_period", tmp - t0, 80);
            if (i < 16 && trig[0]) cnt0++;
            t0 = tmp;
        end
        check("t1_voice0_hits", cnt0, 4);

        // Test 2: shrink 4 -> 2 once the counter has passed the new end; advance on next tick.
        n = 0;
        while (!(m_state == 2 && m_cnt == 2) && n < 500) begin @(negedge clkin); n++; end
        check("t2_reach_cnt2", m_cnt, 2);
        t0 = cyc;
        samples_per_step = 16'd2;
        wait_strobe(t1);
        check("t2_adv_next_tick", (t1 - t0) <= 24, 1);
        wait_strobe(t1);
        wait_strobe(t2);
        check("t2_period", t2 - t1, 40);

        // Table: steady-state strobe spacing for several lengths, 0 treated as 1.
        for (int i = 0; i < 5; i++) begin
            samples_per_step = lv[i].sps;
            wait_strobe(tmp);
            wait_strobe(t1);
            wait_strobe(t2);
            check("tbl_period", t2 - t1, lv[i].period);
        end

        // Test 5: clear voice1 step 3 on the same edge that enters step 3.
        samples_per_step = 16'd1;
        wait_strobe(tmp);
        n = 0;
        while (!(m_state == 2 && m_step == 2) && n < 1000) begin @(negedge clkin); n++; end
        check("t5_at_step2", m_step, 2);
        n = 0;
        while (cyc != tick_due - 1 && n < 100) begin @(negedge clkin); n++; end
        check("t5_align", cyc, tick_due - 1);
        wr_en = 1'b1; wr_voice = 2'd1; wr_step = 4'd3; wr_data = 1'b0;
        @(negedge clkin);
        wr_en = 1'b0;
        seen3 = 0; n = 0;
        if (step_strobe && step_idx == 4'd3) begin trig3[0] = trig; seen3 = 1; end
        while (seen3 < 2 && n < 40) begin
            wait_strobe(tmp);
            if (step_idx == 4'd3) begin trig3[seen3] = trig; seen3++; end
            n++;
        end
        check("t5_entries_seen", seen3, 2);
        check("t5_old_bit_fires", trig3[0][1], 1);
        check("t5_next_lap_cleared", trig3[1][1], 0);

        // Test 4: stop during step 6, stay stopped 100 cycles, restart from step 0.
        n = 0;
        do begin wait_strobe(tmp); n++; end while (step_idx != 4'd6 && n < 40);
        check("t4_at_step6", step_idx, 6);
        repeat (5) @(negedge clkin);
        run = 1'b0;
        acc = '0; cnt0 = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clkin);
            acc |= trig;
            if (step_strobe) cnt0++;
        end
        check("t4_stop_busy", busy, 0);
        check("t4_stop_step", step_idx, 0);
        check("t4_stop_trig", acc, 0);
        check("t4_stop_strobes", cnt0, 0);
        run = 1'b1;
        wait_strobe(tmp);
        check("t4_restart_step", step_idx, 0);
        check("t4_restart_trig", trig, 4'b0001);

        // Reset mid-run clears the pattern: a full lap afterwards produces no triggers.
        repeat (7) @(negedge clkin);
        reset = 1'b1; run = 1'b0;
        @(negedge clkin);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_step", step_idx, 0);
        check("mid_rst_strobe", step_strobe, 0);
        @(negedge clkin);
        reset = 1'b0;
        repeat (10) @(negedge clkin);
        run = 1'b1;
        acc = '0;
        for (int i = 0; i < NS; i++) begin
            wait_strobe(tmp);
            acc |= trig;
        end
        check("mid_rst_pattern_clear", acc, 0);

`ifdef DRUM_SEQ_SWING_EN
        // Swing: even steps lengthened, odd steps shortened by the clamped swing amount.
        write_bit(2, 1, 1'b1);
        for (int i = 0; i < 2; i++) begin
            samples_per_step = sv[i].sps;
            swing_samples    = sv[i].swing;
            wait_strobe(tmp);
            wait_strobe(tmp);
            for (int k = 0; k < 2; k++) begin
                wait_strobe(t1);
                s0 = int'(step_idx);
                wait_strobe(t2);
                check("swing_len", t2 - t1, (s0 % 2 == 0) ? sv[i].even_p : sv[i].odd_p);
            end
        end
        swing_samples = '0;
`endif

        run = 1'b0;
        repeat (5) @(negedge clkin);
        check("sb_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
